// File: rtl/demux4_pkg.sv
// Shared constants and FSM encoding for the 1-to-4 stream demultiplexer.
package demux4_pkg;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/demux_out_slot.sv
// One registered output slot: holds a single beat until its consumer takes it.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // A load in the same cycle as a drain takes precedence so a channel sustains one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 packet demultiplexer: the first beat's in_sel picks the channel for the whole packet.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic                      busy,
    input  logic                      cnt_clr,
    output logic [NUM_OUT*CNT_W-1:0]  pkt_cnt
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_lock_sel;
    logic [SEL_W-1:0] w_lock_nxt;
    logic [SEL_W-1:0] w_target;
    logic             w_accept;

    // Target mux kept outside the FSM process so in_ready has no loop through next-state logic.
    assign w_target = (r_state == LOCKED) ? r_lock_sel : in_sel;
    assign in_ready = !out_valid[w_target] || out_ready[w_target];
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_sel <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_sel;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_nxt = LOCKED;
                    w_lock_nxt  = in_sel;
                end
            end
            LOCKED: begin
                if (w_accept && in_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
        logic             w_load;
        logic [CNT_W-1:0] r_cnt;

        assign w_load = w_accept && (w_target == SEL_W'(k));

        demux_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load),
            .i_data  (in_data),
            .i_last  (in_last),
            .i_ready (out_ready[k]),
            .o_valid (out_valid[k]),
            .o_data  (out_data[k*DATA_W +: DATA_W]),
            .o_last  (out_last[k])
        );

        // Clear beats a coincident packet completion; the counter wraps naturally.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_load && in_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign pkt_cnt[k*CNT_W +: CNT_W] = r_cnt;
    end
endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench: directed packet sequence with a per-channel scoreboard and reference model.
module tb_demux4_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic        busy;
    logic        cnt_clr;
    logic [31:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    // Scoreboard: one queue of {last,data} per channel; model of lock state and counters.
    logic [8:0] q [4][$];
    logic       m_locked;
    logic [1:0] m_lsel;
    logic [7:0] m_cnt [4];
    logic [3:0] m_ev;
    logic [1:0] m_tgt;
    logic       m_acc;

    demux4_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .cnt_clr   (cnt_clr),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                m_cnt[k] = 8'd0;
            end
            m_locked = 1'b0;
            m_lsel   = 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) m_ev[k] = (q[k].size() != 0);
            chk("out_valid", 64'(out_valid), 64'(m_ev));
            chk("busy", 64'(busy), 64'(m_locked));
            chk("pkt_cnt", 64'(pkt_cnt), 64'({m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}));
            for (int k = 0; k < 4; k++) begin
                if (m_ev[k]) begin
                    chk("out_data", 64'(out_data[k*8 +: 8]), 64'(q[k][0][7:0]));
                    chk("out_last", 64'(out_last[k]), 64'(q[k][0][8]));
                end
            end
            m_tgt = m_locked ? m_lsel : in_sel;
            chk("in_ready", 64'(in_ready), 64'(!m_ev[m_tgt] || out_ready[m_tgt]));
            m_acc = in_valid && in_ready;
            for (int k = 0; k < 4; k++) begin
                if (m_ev[k] && out_ready[k]) void'(q[k].pop_front());
                if (cnt_clr) m_cnt[k] = 8'd0;
            end
            if (m_acc) begin
                q[m_tgt].push_back({in_last, in_data});
                if (in_last && !cnt_clr) m_cnt[m_tgt] = m_cnt[m_tgt] + 8'd1;
                if (!m_locked && !in_last) begin
                    m_locked = 1'b1;
                    m_lsel   = in_sel;
                end else if (m_locked && in_last) begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    // Presents one beat and holds it until accepted; returns the number of cycles it took.
    task automatic beat(input logic [1:0] s, input logic [7:0] d, input logic l, output int n);
        logic acc;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        in_last   = 1'b0;
        out_ready = 4'b1111;
        cnt_clr   = 1'b0;
        idle(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: single beat to ch2
        beat(2'd2, 8'hA5, 1'b1, n);
        chk("t1_valid", 64'(out_valid), 64'h4);
        chk("t1_data", 64'(out_data[23:16]), 64'hA5);
        chk("t1_cnt2", 64'(pkt_cnt[23:16]), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        idle(2);

        // 2: 3-beat packet stays on ch1 despite in_sel changes
        beat(2'd1, 8'h11, 1'b0, n);
        chk("t2_busy_on", 64'(busy), 64'd1);
        chk("t2_valid0", 64'(out_valid), 64'h2);
        beat(2'd3, 8'h22, 1'b0, n);
        chk("t2_valid1", 64'(out_valid), 64'h2);
        beat(2'd3, 8'h33, 1'b1, n);
        chk("t2_busy_off", 64'(busy), 64'd0);
        chk("t2_cnt1", 64'(pkt_cnt[15:8]), 64'd1);
        chk("t2_data", 64'(out_data[15:8]), 64'h33);
        idle(2);

        // 3: stalled ch0 backpressures the input
        out_ready = 4'b1110;
        beat(2'd0, 8'h44, 1'b0, n);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h55;
        in_last  = 1'b1;
        @(negedge clk);
        chk("t3_stall0", 64'(in_ready), 64'd0);
        idle(1);
        @(negedge clk);
        chk("t3_stall1", 64'(in_ready), 64'd0);
        chk("t3_hold", 64'(out_data[7:0]), 64'h44);
        idle(1);
        out_ready = 4'b1111;
        @(negedge clk);
        chk("t3_release", 64'(in_ready), 64'd1);
        idle(1);
        in_valid = 1'b0;
        chk("t3_second", 64'(out_data[7:0]), 64'h55);
        chk("t3_cnt0", 64'(pkt_cnt[7:0]), 64'd1);
        idle(2);

        // 4: full stalled ch0 does not block ch3
        out_ready = 4'b1110;
        beat(2'd0, 8'h66, 1'b1, n);
        beat(2'd3, 8'h77, 1'b1, n);
        chk("t4_ch3_immediate", 64'(n), 64'd1);
        chk("t4_ch0_data", 64'(out_data[7:0]), 64'h66);
        chk("t4_ch3_data", 64'(out_data[31:24]), 64'h77);
        chk("t4_valid", 64'(out_valid), 64'h9);
        out_ready = 4'b1111;
        idle(2);

        // 5: reset in the middle of a packet
        beat(2'd2, 8'h81, 1'b0, n);
        beat(2'd2, 8'h82, 1'b0, n);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_data", 64'(out_data), 64'd0);
        chk("t5_last", 64'(out_last), 64'd0);
        chk("t5_cnt", 64'(pkt_cnt), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        beat(2'd0, 8'h99, 1'b1, n);
        chk("t5_after", 64'(out_valid), 64'h1);
        chk("t5_after_data", 64'(out_data[7:0]), 64'h99);
        idle(2);

        // 6: counter wrap and clear priority
        for (int i = 0; i < 256; i++) beat(2'd1, 8'(i), 1'b1, n);
        chk("t6_wrap", 64'(pkt_cnt[15:8]), 64'd0);
        beat(2'd1, 8'hC3, 1'b1, n);
        chk("t6_one", 64'(pkt_cnt[15:8]), 64'd1);
        cnt_clr = 1'b1;
        beat(2'd1, 8'hC4, 1'b1, n);
        cnt_clr = 1'b0;
        chk("t6_clr", 64'(pkt_cnt), 64'd0);
        idle(3);

        for (int k = 0; k < 4; k++) chk("drained", 64'(q[k].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
